// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and the
// data stage, one transaction at a time. Data has priority; fetch is protected from starvation.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_byte,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              starved;
  logic              fetch_wins;

  // Fetch wins when it is alone, or when it has lost too many contested rounds.
  assign starved    = (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign fetch_wins = if_req & (~dm_req | starved);

  // Acks are combinational on state and ready; a cycle held in reset never completes.
  assign if_ack  = (state == BUSY_I) & mem_ready & ~reset;
  assign dm_ack  = (state == BUSY_D) & mem_ready & ~reset;
  assign stall_f = if_req & ~if_ack;
  assign stall_m = dm_req & ~dm_ack;

  // Read data is forwarded in the ack cycle and held from the register afterwards.
  assign if_rdata = if_ack ? mem_rdata : if_rdata_q;
  assign dm_rdata = (dm_ack & ~mem_we) ? mem_rdata : dm_rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_byte   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_req && !fetch_wins) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_byte  <= dm_byte;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (if_req && !starved) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end else if (if_req) begin
            state      <= BUSY_I;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_byte   <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            if_rdata_q <= mem_rdata;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (!mem_we) begin
              dm_rdata_q <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, lone fetch, contention,
// starvation release, byte store and reset mid-transaction.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic        dm_byte;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        stall_f;
  logic        stall_m;
  logic        mem_req;
  logic        mem_we;
  logic        mem_byte;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge; inputs are then driven 1 time unit after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Let combinational outputs settle after input changes before sampling.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b1; dm_req = 1'b1;
    if_addr = 32'h0040_0004; dm_addr = 32'h1001_0000;
    dm_we = 1'b0; dm_byte = 1'b0; dm_wdata = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0;

    // Reset with both requesters active
    cyc(); cyc(); settle();
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_if_ack", 32'(if_ack), 32'h0);
    check("rst_dm_ack", 32'(dm_ack), 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    cyc(); settle();
    check("c_grant_data", 32'(mem_req), 32'h1);
    check("c_addr_data", mem_addr, 32'h1001_0000);
    for (int i = 0; i < 3; i++) begin
      check("c_wait_stall_f", 32'(stall_f), 32'h1);
      check("c_wait_dm_ack", 32'(dm_ack), 32'h0);
      check("c_wait_addr", mem_addr, 32'h1001_0000);
      cyc(); settle();
    end
    mem_ready = 1'b1; mem_rdata = 32'h1122_3344; settle();
    check("c_dm_ack", 32'(dm_ack), 32'h1);
    check("c_if_ack_low", 32'(if_ack), 32'h0);
    check("c_dm_rdata", dm_rdata, 32'h1122_3344);
    check("c_stall_m", 32'(stall_m), 32'h0);
    check("c_stall_f", 32'(stall_f), 32'h1);
    cyc();
    dm_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF; settle();
    check("c_idle_gap", 32'(mem_req), 32'h0);
    check("c_dm_rdata_hold", dm_rdata, 32'h1122_3344);
    cyc(); settle();
    check("c_grant_fetch", 32'(mem_req), 32'h1);
    check("c_addr_fetch", mem_addr, 32'h0040_0004);
    check("c_fetch_we", 32'(mem_we), 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h8C08_0000; settle();
    check("c_if_ack", 32'(if_ack), 32'h1);
    check("c_if_rdata", if_rdata, 32'h8C08_0000);
    cyc();
    if_req = 1'b0; mem_ready = 1'b0; settle();

    // Lone fetch with mem_ready held high
    if_req = 1'b1; if_addr = 32'h0040_0000; mem_ready = 1'b1; mem_rdata = 32'h2402_000A; settle();
    check("f_idle_no_ack", 32'(if_ack), 32'h0);
    check("f_idle_req", 32'(mem_req), 32'h0);
    cyc(); settle();
    check("f_mem_req", 32'(mem_req), 32'h1);
    check("f_mem_addr", mem_addr, 32'h0040_0000);
    check("f_if_ack", 32'(if_ack), 32'h1);
    check("f_if_rdata", if_rdata, 32'h2402_000A);
    check("f_stall_f", 32'(stall_f), 32'h0);
    cyc();
    if_req = 1'b0; mem_rdata = 32'h0; settle();
    check("f_ack_pulse", 32'(if_ack), 32'h0);
    check("f_rdata_hold", if_rdata, 32'h2402_000A);
    check("f_stall_after", 32'(stall_f), 32'h0);
    mem_ready = 1'b0;

    // Byte store
    dm_req = 1'b1; dm_we = 1'b1; dm_byte = 1'b1; dm_addr = 32'h1001_0003; dm_wdata = 32'h0000_00AB;
    cyc(); settle();
    check("s_mem_we", 32'(mem_we), 32'h1);
    check("s_mem_byte", 32'(mem_byte), 32'h1);
    check("s_mem_addr", mem_addr, 32'h1001_0003);
    check("s_mem_wdata", mem_wdata, 32'h0000_00AB);
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; settle();
    check("s_dm_ack", 32'(dm_ack), 32'h1);
    check("s_dm_rdata_kept", dm_rdata, 32'h1122_3344);
    cyc();
    dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0; mem_ready = 1'b0; settle();
    check("s_dm_rdata_after", dm_rdata, 32'h1122_3344);
    check("s_idle", 32'(mem_req), 32'h0);

    // Starvation: data wins four contested rounds, fetch the fifth, then data again
    if_req = 1'b1; if_addr = 32'h0040_0008;
    dm_req = 1'b1; dm_addr = 32'h1001_0100; mem_ready = 1'b1; mem_rdata = 32'h0;
    for (int k = 0; k < 6; k++) begin
      cyc(); settle();
      if (k == 4) begin
        check("v_fetch_addr", mem_addr, if_addr);
        check("v_fetch_ack", 32'(if_ack), 32'h1);
        check("v_fetch_no_dack", 32'(dm_ack), 32'h0);
      end else begin
        check("v_data_addr", mem_addr, dm_addr);
        check("v_data_ack", 32'(dm_ack), 32'h1);
        check("v_data_no_iack", 32'(if_ack), 32'h0);
      end
      cyc();
      if (k == 4) if_addr = if_addr + 32'd4;
      else dm_addr = dm_addr + 32'd4;
      settle();
      check("v_idle_gap", 32'(mem_req), 32'h0);
    end
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;

    // Reset while a load is in flight
    dm_req = 1'b1; dm_addr = 32'h1001_0020;
    cyc(); settle();
    check("r_busy", 32'(mem_req), 32'h1);
    reset = 1'b1; dm_req = 1'b0;
    cyc(); settle();
    check("r_mem_req", 32'(mem_req), 32'h0);
    check("r_mem_addr", mem_addr, 32'h0);
    check("r_dm_ack", 32'(dm_ack), 32'h0);
    check("r_dm_rdata", dm_rdata, 32'h0);
    reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA; settle();
    check("r_ready_ignored", 32'(dm_ack), 32'h0);
    check("r_no_if_ack", 32'(if_ack), 32'h0);
    cyc(); settle();
    check("r_still_idle", 32'(mem_req), 32'h0);
    check("r_still_no_ack", 32'(dm_ack), 32'h0);
    check("r_rdata_zero", dm_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
